// File: rtl/icache_miss_ctrl.sv
// I-cache miss sequencer: on a hit-check miss it stalls the pipe, fetches the
// line over DFP, writes it into the arrays (round-robin victim per set) and keeps it for forwarding.
module icache_miss_ctrl #(
  parameter int SETS      = 16,
  parameter int WAYS      = 4,
  parameter int LINE_BITS = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [31:0]                    req_addr,
  input  logic                           req_hit,
  input  logic                           req_fwd,
  input  logic                           kill,
  output logic                           stall,
  output logic [31:0]                    dfp_addr,
  output logic                           dfp_read,
  input  logic [LINE_BITS-1:0]           dfp_rdata,
  input  logic                           dfp_resp,
  output logic                           arr_we,
  output logic [$clog2(SETS)-1:0]        arr_set,
  output logic [$clog2(WAYS)-1:0]        arr_way,
  output logic [32-$clog2(SETS)-5-1:0]   arr_tag,
  output logic [LINE_BITS-1:0]           arr_wdata,
  output logic                           fill_valid,
  output logic [31:0]                    fill_raddr,
  output logic [LINE_BITS-1:0]           fill_rdata
);

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        miss_addr;
  logic [WAY_W-1:0]   rr [SETS];
  logic               miss;
  logic [SET_W-1:0]   miss_set;

  assign miss     = req_valid & ~req_hit & ~req_fwd & ~kill;
  assign miss_set = miss_addr[SET_W+4:5];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Line-aligned miss address; only meaningful while REQ/FILL are active.
  always_ff @(posedge clk) begin
    if (state == IDLE && miss) miss_addr <= req_addr & ~32'h1f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_valid <= 1'b0;
      fill_raddr <= '0;
      fill_rdata <= '0;
    end else if (state == REQ && dfp_resp) begin
      fill_valid <= 1'b1;
      fill_raddr <= miss_addr;
      fill_rdata <= dfp_rdata;
    end
  end

  // Victim pointers: power-of-two WAYS lets the counter wrap by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) rr[i] <= '0;
    end else if (state == FILL) begin
      rr[miss_set] <= rr[miss_set] + WAY_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    dfp_read  = 1'b0;
    dfp_addr  = '0;
    arr_we    = 1'b0;
    arr_set   = '0;
    arr_way   = '0;
    arr_tag   = '0;
    arr_wdata = '0;
    case (state)
      IDLE: begin
        stall = miss;
        if (miss) state_nxt = REQ;
      end
      REQ: begin
        stall    = 1'b1;
        dfp_read = 1'b1;
        dfp_addr = miss_addr;
        if (dfp_resp) state_nxt = FILL;
      end
      FILL: begin
        stall     = 1'b1;
        arr_we    = 1'b1;
        arr_set   = miss_set;
        arr_tag   = miss_addr[31:SET_W+5];
        arr_way   = rr[miss_set];
        arr_wdata = fill_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
